// File: rtl/fp32_adder_if.sv
// Operand/result bundle for the registered binary32 adder.
// The producer drives the operands and the adder returns the sum.
interface fp32_adder_if;
   logic [31:0] FP_in1;
   logic [31:0] FP_in2;
   logic [31:0] FP_out;

   modport master (output FP_in1, FP_in2, input FP_out);
   modport slave  (input FP_in1, FP_in2, output FP_out);
endinterface

// File: rtl/fp32_adder.sv
// Single-cycle IEEE-754 binary32 adder with round-to-nearest-even and flush-to-zero.
// Registered output: the sum of the operands present at a rising edge appears after that edge.
module fp32_adder (
   input  logic        clk,
   input  logic        rst_n,
   fp32_adder_if.slave bus
);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic [31:0]       sum_d, sum_q;
   logic              sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, a_big;
   logic [30:0]       mag_a, mag_b;
   logic              s_big;
   logic [7:0]        e_big, e_sml, e_diff;
   logic [23:0]       m_big, m_sml;
   logic [49:0]       sml_wide;
   logic [26:0]       big_ext, sml_al, diff27, norm;
   logic [27:0]       sum28;
   logic [4:0]        lz;
   logic signed [9:0] e_norm;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       hit;
      n   = 5'd0;
      hit = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!hit && v[i]) hit = 1'b1;
         else if (!hit)    n   = n + 5'd1;
      end
      return n;
   endfunction

   // m holds a 24-bit significand (leading 1 at bit 26) followed by guard, round, sticky.
   function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                              input logic [26:0] m);
      logic              up;
      logic [24:0]       mr;
      logic signed [9:0] er;
      logic [22:0]       frac;
      up   = m[2] & (m[1] | m[0] | m[3]);
      mr   = {1'b0, m[26:3]} + {24'd0, up};
      er   = e;
      frac = mr[22:0];
      if (mr[24]) begin
         er   = e + 10'sd1;
         frac = mr[23:1];
      end
      if (er >= 10'sd255) round_pack = {s, 8'hFF, 23'd0};
      else                round_pack = {s, er[7:0], frac};
   endfunction

   always_comb begin
      sa     = bus.FP_in1[31];
      sb     = bus.FP_in2[31];
      zero_a = (bus.FP_in1[30:23] == 8'd0);
      zero_b = (bus.FP_in2[30:23] == 8'd0);
      nan_a  = (bus.FP_in1[30:23] == 8'hFF) && (bus.FP_in1[22:0] != 23'd0);
      nan_b  = (bus.FP_in2[30:23] == 8'hFF) && (bus.FP_in2[22:0] != 23'd0);
      inf_a  = (bus.FP_in1[30:23] == 8'hFF) && (bus.FP_in1[22:0] == 23'd0);
      inf_b  = (bus.FP_in2[30:23] == 8'hFF) && (bus.FP_in2[22:0] == 23'd0);
      // Subnormals become zeros here, so the magnitude compare treats them as zero.
      mag_a  = zero_a ? 31'd0 : bus.FP_in1[30:0];
      mag_b  = zero_b ? 31'd0 : bus.FP_in2[30:0];
      a_big  = (mag_a >= mag_b);
      s_big  = a_big ? sa : sb;
      e_big  = a_big ? mag_a[30:23] : mag_b[30:23];
      e_sml  = a_big ? mag_b[30:23] : mag_a[30:23];
      m_big  = a_big ? {~zero_a, mag_a[22:0]} : {~zero_b, mag_b[22:0]};
      m_sml  = a_big ? {~zero_b, mag_b[22:0]} : {~zero_a, mag_a[22:0]};

      e_diff   = e_big - e_sml;
      sml_wide = {m_sml, 26'd0} >> e_diff;
      sml_al   = (e_diff >= 8'd26) ? {26'd0, |m_sml}
                                   : {sml_wide[49:24], |sml_wide[23:0]};
      big_ext  = {m_big, 3'b000};
      sum28    = {1'b0, big_ext} + {1'b0, sml_al};
      diff27   = big_ext - sml_al;
      lz       = lzc27(diff27);

      norm   = 27'd0;
      e_norm = 10'sd0;
      sum_d  = 32'd0;
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
         sum_d = QNAN;
      end else if (inf_a) begin
         sum_d = bus.FP_in1;
      end else if (inf_b) begin
         sum_d = bus.FP_in2;
      end else if (zero_a && zero_b) begin
         sum_d = {sa & sb, 31'd0};
      end else if (sa == sb) begin
         // A carry out folds the dropped LSB into sticky.
         if (sum28[27]) begin
            norm   = {sum28[27:2], |sum28[1:0]};
            e_norm = $signed({2'b00, e_big}) + 10'sd1;
         end else begin
            norm   = sum28[26:0];
            e_norm = $signed({2'b00, e_big});
         end
         sum_d = round_pack(s_big, e_norm, norm);
      end else if (diff27 == 27'd0) begin
         sum_d = 32'd0;
      end else begin
         norm   = diff27 << lz;
         e_norm = $signed({2'b00, e_big}) - $signed({5'd0, lz});
         sum_d  = (e_norm <= 10'sd0) ? {s_big, 31'd0} : round_pack(s_big, e_norm, norm);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= 32'd0;
      else        sum_q <= sum_d;
   end

   assign bus.FP_out = sum_q;
endmodule

// File: tb/tb_fp32_adder.sv
// Directed and random checks of fp32_adder against a double-precision reference
// rounded to binary32 (RNE, flush-to-zero), through an expected-result queue.
module tb_fp32_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp32_adder_if bus();
   fp32_adder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   logic [31:0] exq[$];
   string       tq[$];

   function automatic real f2d(input logic [31:0] f);
      logic [63:0] d;
      logic [10:0] de;
      if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
      else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
      else begin
         de = 11'(f[30:23]) + 11'd896;
         d  = {f[31], de, f[22:0], 29'd0};
      end
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] d2f(input real r);
      logic [63:0] b;
      int          ue;
      logic [52:0] mant;
      logic [23:0] m24;
      logic [28:0] rest;
      logic [24:0] m25;
      logic        up;
      b = $realtobits(r);
      if (b[62:52] == 11'h7FF) return (b[51:0] != 52'd0) ? 32'h7FC00000 : {b[63], 31'h7F800000};
      if (b[62:52] == 11'd0) return {b[63], 31'd0};
      ue = int'(b[62:52]) - 1023;
      if (ue < -126) return {b[63], 31'd0};
      mant = {1'b1, b[51:0]};
      m24  = mant[52:29];
      rest = mant[28:0];
      up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && m24[0]);
      m25  = {1'b0, m24} + 25'(up);
      if (m25[24]) begin
         ue  = ue + 1;
         m24 = m25[24:1];
      end else begin
         m24 = m25[23:0];
      end
      if (ue > 127) return {b[63], 31'h7F800000};
      return {b[63], 8'(ue + 127), m24[22:0]};
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      return d2f(f2d(x) + f2d(y));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: FP_out=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input string tag);
      @(negedge clk);
      bus.FP_in1 = x;
      bus.FP_in2 = y;
      exq.push_back(e);
      tq.push_back(tag);
   endtask

   task automatic collect();
      logic [31:0] e;
      string       t;
      @(posedge clk);
      #1;
      if (exq.size() == 0) begin
         check("queue_empty", bus.FP_out, 32'hXXXXXXXX);
      end else begin
         e = exq.pop_front();
         t = tq.pop_front();
         check(t, bus.FP_out, e);
      end
   endtask

   task automatic step(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input string tag);
      drive(x, y, e, tag);
      collect();
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          eb, sel;

      rst_n      = 1'b1;
      bus.FP_in1 = 32'h3F800000;
      bus.FP_in2 = 32'h3F800000;
      @(posedge clk);
      #1;
      check("pre_reset", bus.FP_out, 32'h40000000);

      // Reset mid-cycle must clear the output without a clock edge.
      #2 rst_n = 1'b0;
      #1 check("rst_async", bus.FP_out, 32'h00000000);
      bus.FP_in1 = 32'h7F7FFFFF;
      bus.FP_in2 = 32'h3F800000;
      repeat (3) @(posedge clk);
      #1 check("rst_hold", bus.FP_out, 32'h00000000);

      @(negedge clk);
      rst_n      = 1'b1;
      bus.FP_in1 = 32'h3FC00000;
      bus.FP_in2 = 32'h40100000;
      exq.push_back(32'h40700000);
      tq.push_back("rst_release");
      collect();

      step(d2f(0.6048),  d2f(0.0662),  ref_add(d2f(0.6048),  d2f(0.0662)),  "mix_pp");
      step(d2f(-0.6048), d2f(7.0662),  ref_add(d2f(-0.6048), d2f(7.0662)),  "mix_np");
      step(d2f(5.6048),  d2f(-1.0662), ref_add(d2f(5.6048),  d2f(-1.0662)), "mix_pn");

      step(32'h3F800000, 32'hBF800000, 32'h00000000, "cancel");
      step(32'h80000000, 32'h80000000, 32'h80000000, "negzero_sum");
      step(32'h00000000, 32'h80000000, 32'h00000000, "mixed_zero");
      step(32'h00400000, 32'h3F800000, 32'h3F800000, "subnorm_flush");
      step(32'h80000001, 32'h00000000, 32'h00000000, "subnorm_plus_zero");
      step(32'h3F800000, 32'hBF7FFFFF, 32'h33800000, "renorm_sub");
      step(32'h00800001, 32'h80800000, 32'h00000000, "underflow_ftz");

      step(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_even_down");
      step(32'h3F800000, 32'h33800001, 32'h3F800001, "above_tie");
      step(32'h3F800001, 32'h33800000, 32'h3F800002, "tie_even_up");

      step(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
      step(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
      step(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_a");
      step(32'h3F800000, 32'hFFC12345, 32'h7FC00000, "nan_b");
      step(32'hFF800000, 32'h3F800000, 32'hFF800000, "inf_plus_fin");

      // A reset between drive and capture throws the pending sum away.
      drive(32'h3F800000, 32'h3F800000, 32'h40000000, "discarded");
      #2 rst_n = 1'b0;
      #1 check("rst_discard_async", bus.FP_out, 32'h00000000);
      exq.delete();
      tq.delete();
      @(posedge clk);
      #1 check("rst_discard_hold", bus.FP_out, 32'h00000000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 1000; i++) begin
         ra  = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         sel = int'($urandom_range(0, 7));
         if (sel == 0) begin
            rb = {~ra[31], ra[30:0]};
         end else if (sel < 4) begin
            eb = int'(ra[30:23]) + int'($urandom_range(0, 4)) - 2;
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
         end else begin
            rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         end
         step(ra, rb, ref_add(ra, rb), "random");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
